// File: rtl/led7_scan.sv
// Time-multiplexed seven-segment driver for a common-anode bank: latches hex nibbles,
// scans one digit per slot with ghost blanking, decimal points and leading-zero blanking.
module led7_scan #(
   parameter int DIGITS       = 4,
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   in_value,
   input  logic                  in_load,
   input  logic [DIGITS-1:0]     in_dp,
   input  logic                  in_blank_lz,
   output logic [6:0]            out_led,
   output logic                  out_dp,
   output logic [DIGITS-1:0]     out_an
);

   localparam int CW = $clog2(PRESCALE);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [CW-1:0]         cnt_reg;
   logic [IW-1:0]         idx_reg;
   logic [4*DIGITS-1:0]   val_reg;
   logic [DIGITS-1:0]     dp_reg;

   logic [3:0]            nib [DIGITS];
   logic [DIGITS-1:0]     sel;
   logic [DIGITS-1:0]     supp;
   logic                  slot_end;

   logic [6:0]            led_next;
   logic                  dp_next;
   logic [DIGITS-1:0]     an_next;
   logic [3:0]            nib_cur;
   logic                  supp_cur;

   function automatic logic [6:0] decode(input logic [3:0] code);
      logic [6:0] seg;
      case (code)
         4'h0: seg = 7'b0000001;
         4'h1: seg = 7'b1001111;
         4'h2: seg = 7'b0010010;
         4'h3: seg = 7'b0000110;
         4'h4: seg = 7'b1001100;
         4'h5: seg = 7'b0100100;
         4'h6: seg = 7'b0100000;
         4'h7: seg = 7'b0001111;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0000100;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b1100000;
         4'hC: seg = 7'b0110001;
         4'hD: seg = 7'b1000010;
         4'hE: seg = 7'b0110000;
         default: seg = 7'b0111000;
      endcase
      return seg;
   endfunction

   // Digit i is a leading zero when it and every more significant nibble is zero.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nib[gi]  = val_reg[4*gi +: 4];
      assign sel[gi]  = (idx_reg == IW'(gi));
      if (gi == 0) begin : g_lsd
         assign supp[gi] = 1'b0;
      end else begin : g_upper
         assign supp[gi] = (val_reg[4*DIGITS-1:4*gi] == '0);
      end
   end

   assign slot_end = (cnt_reg == CW'(PRESCALE - 1));

   always_comb begin
      nib_cur  = 4'h0;
      supp_cur = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (sel[i]) begin
            nib_cur  = nib[i];
            supp_cur = supp[i];
         end
      end
   end

   always_comb begin
      led_next = 7'b1111111;
      dp_next  = 1'b1;
      an_next  = '1;
      if (!(cnt_reg < CW'(BLANK_CYCLES))) begin
         an_next = ~sel;
         dp_next = ~|(dp_reg & sel);
         if (!(in_blank_lz && supp_cur))
            led_next = decode(nib_cur);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
         idx_reg <= '0;
         val_reg <= '0;
         dp_reg  <= '0;
         out_led <= 7'b1111111;
         out_dp  <= 1'b1;
         out_an  <= '1;
      end else begin
         if (in_load) begin
            val_reg <= in_value;
            dp_reg  <= in_dp;
         end
         if (slot_end) begin
            cnt_reg <= '0;
            idx_reg <= (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
         out_led <= led_next;
         out_dp  <= dp_next;
         out_an  <= an_next;
      end
   end

endmodule
